// File: rtl/calc_sequencer_if.sv
// Command/response stream bundle between host logic and calc_sequencer.
// master = host side (issues commands, consumes responses); slave = sequencer side.
interface calc_sequencer_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RES_WIDTH = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [WIDTH-1:0]     cmd_a;
    logic [WIDTH-1:0]     cmd_b;
    logic [3:0]           cmd_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [RES_WIDTH-1:0] rsp_data;
    logic [1:0]           rsp_err;
    logic [3:0]           rsp_op;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_op
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_op
    );
endinterface

// File: rtl/calc_sequencer.sv
// Sequencer driving the combinational calculator datapath from a valid/ready command stream.
// Optional feature: define CALC_SEQ_DIV0_BYPASS_EN to answer div/mod by zero locally.
module calc_sequencer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RES_WIDTH = 32,
    parameter int unsigned SETTLE    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_sequencer_if.slave      bus,
    output logic [WIDTH-1:0]     alu_input1,
    output logic [WIDTH-1:0]     alu_input2,
    output logic [3:0]           alu_op_code,
    input  logic [RES_WIDTH-1:0] alu_output1,
    input  logic [1:0]           alu_err_code,
    output logic [15:0]          done_count,
    output logic [15:0]          err_count
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 local_q, local_d;
    logic [WIDTH-1:0]     alu_a_q, alu_a_d;
    logic [WIDTH-1:0]     alu_b_q, alu_b_d;
    logic [3:0]           alu_op_q, alu_op_d;
    logic [RES_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]           rsp_err_q, rsp_err_d;
    logic [3:0]           rsp_op_q, rsp_op_d;
    logic [15:0]          done_q, done_d;
    logic [15:0]          errc_q, errc_d;

    logic illegal_op;
    logic div0_bypass;

    assign illegal_op = bus.cmd_op > 4'd4;

`ifdef CALC_SEQ_DIV0_BYPASS_EN
    assign div0_bypass = ((bus.cmd_op == 4'd3) || (bus.cmd_op == 4'd4)) && (bus.cmd_b == '0);
`else
    assign div0_bypass = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        local_d    = local_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rsp_op_d   = rsp_op_q;
        done_d     = done_q;
        errc_d     = errc_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    rsp_op_d = bus.cmd_op;
                    state_d  = StWait;
                    if (illegal_op || div0_bypass) begin
                        // Locally answered: result is preloaded and a single wait cycle
                        // gives these responses their one-cycle latency.
                        rsp_data_d = '0;
                        rsp_err_d  = illegal_op ? 2'b11 : 2'b10;
                        local_d    = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        alu_a_d  = bus.cmd_a;
                        alu_b_d  = bus.cmd_b;
                        alu_op_d = bus.cmd_op;
                        local_d  = 1'b0;
                        cnt_d    = SettleLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    if (!local_q) begin
                        rsp_data_d = alu_output1;
                        rsp_err_d  = alu_err_code;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                    done_d  = done_q + 16'd1;
                    if ((rsp_err_q != 2'b00) && (errc_q != 16'hFFFF)) begin
                        errc_d = errc_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            local_q    <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
            rsp_op_q   <= '0;
            done_q     <= '0;
            errc_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            local_q    <= local_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_op_q   <= rsp_op_d;
            done_q     <= done_d;
            errc_q     <= errc_d;
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_op    = rsp_op_q;
    assign alu_input1    = alu_a_q;
    assign alu_input2    = alu_b_q;
    assign alu_op_code   = alu_op_q;
    assign done_count    = done_q;
    assign err_count     = errc_q;

endmodule
